noc_eject_arbiter: RTL and testbench
====================================

# noc_eject_arbiter

Per-node ejection stage between a router's LOCAL output port and its core or cache controller. Buffers each virtual channel independently and serialises all VCs onto one flit stream with an explicit VC tag. Uses round-robin arbitration with optional packet-atomic locking. Every VC is delivered to the core, where previously only VC0 was forwarded. One instance per mesh node, parametrised in width, VC count, buffer depth and lock mode.

## Interface
Parameters:
- FLIT_WIDTH, 128, flit width in bits
- VC_COUNT, 3, number of virtual channels (≥1)
- BUFFER_DEPTH, 4, per-VC FIFO depth in flits (power of two, ≥2)
- PACKET_LOCK, 1, 1 = hold grant on a VC from head flit until tail flit; 0 = per-flit round-robin
- TAIL_BIT, FLIT_WIDTH-2, bit index of the tail marker inside a flit

Ports (VCW = max(1,$clog2(VC_COUNT)), CW = $clog2(BUFFER_DEPTH+1)):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rtr_flit_in  in  VC_COUNT×FLIT_WIDTH  per-VC flit from router LOCAL output
- rtr_valid_in  in  VC_COUNT  per-VC valid
- rtr_ready_out  out  VC_COUNT  per-VC ready toward router
- core_flit_out  out  FLIT_WIDTH  selected flit
- core_vc_out  out  VCW  VC index of core_flit_out
- core_valid_out  out  1  flit available
- core_ready_in  in  1  core accepts flit
- vc_occupancy  out  VC_COUNT×CW  per-VC FIFO fill level

## Operation
- Push: VC v is written when rtr_valid_in[v] && rtr_ready_out[v].
- rtr_ready_out[v] is registered: 1 iff the next-cycle count of VC v is below BUFFER_DEPTH. No combinational path from core_ready_in.
- Pop: head of the granted VC is removed when core_valid_out && core_ready_in.
- Grant selection, combinational from registered state:
  - Locked: grant = lock_vc. core_valid_out = !empty[lock_vc]. Other VCs are never offered while locked, even if lock_vc is empty.
  - Unlocked: grant = first non-empty VC scanning rr_ptr+1, rr_ptr+2, … modulo VC_COUNT. If all are empty, core_valid_out = 0 and core_flit_out/core_vc_out are don't-care but must hold their last value.
- On each pop, rr_ptr ← grant.
- PACKET_LOCK=1:
  - Popped flit with tail bit 0 → lock ← 1, lock_vc ← grant.
  - Popped flit with tail bit 1 → lock ← 0. A single-flit packet has head and tail both set and never locks.
- PACKET_LOCK=0: lock is held at 0.
- core_valid_out must not drop while core_ready_in is low; a valid offer stays stable until accepted. A higher-priority VC becoming non-empty does not change the current offer.
- Reset mid-operation: all FIFOs are flushed and lock is cleared immediately, asynchronously. In-flight flits are discarded.

## Timing
- Reset values:
  - rtr_ready_out = '0.
  - core_valid_out = 0, core_flit_out = '0, core_vc_out = 0, vc_occupancy = '0.
  - rr_ptr = VC_COUNT-1, so VC0 wins first.
  - lock = 0.
- First clk edge after reset release: rtr_ready_out = all ones.
- Latency: a flit pushed into an empty, unblocked VC at edge N appears on core_*_out after edge N, in the same cycle that is visible to the core.
- Throughput: 1 flit/cycle total output; 1 flit/cycle per VC input.
- Full: once a VC's count reaches BUFFER_DEPTH, ready drops on the following cycle. A simultaneous push and pop on a full VC is impossible, because ready is already 0 (no pass-through).
- Simultaneous push and pop on a non-full VC: count is unchanged and both succeed.
- Pointer wrap: read and write pointers are log2(BUFFER_DEPTH) bits and wrap naturally. Count is CW bits, range 0..BUFFER_DEPTH.
- vc_occupancy reflects the registered count (post-edge).

## Structure
- noc_pkg holds:
  - Flit field positions: HEAD_BIT = FLIT_WIDTH-1, TAIL_BIT = FLIT_WIDTH-2, VC field.
  - The port enum (NORTH, EAST, SOUTH, WEST, LOCAL).
  - The vc_idx_t typedef.
- Sub-module noc_vc_fifo (params FLIT_WIDTH, DEPTH) provides push, pop, head, empty, count and registered ready. It is instantiated VC_COUNT times in a generate loop.
- The arbiter, rr_ptr and lock state live in the top module.

## Test plan
- Reset then single flit: push flit 0x…A5 (tail=1) on VC2 → core_valid_out=1, core_vc_out=2, core_flit_out=0x…A5 after one edge. rtr_ready_out=3'b111 throughout.
- Round-robin: all VCs hold 2 single-flit packets, core_ready_in=1 → output VC order 0,1,2,0,1,2 with no idle cycles.
- Packet lock: VC1 holds a 3-flit packet (tail on flit 3), VC0 holds a single flit, PACKET_LOCK=1 → order is VC1 ×3, then VC0. With PACKET_LOCK=0 → order interleaves VC1, VC0, VC1, VC1.
- Backpressure/full: core_ready_in=0 while pushing 5 flits on VC0 at DEPTH=4 → rtr_ready_out[0]=0 after the 4th push, vc_occupancy[0]=4, 5th flit is held by the router. Offer stays stable. Release → 4 flits in FIFO order, then ready returns.
- Locked on empty VC: VC2 head popped (tail=0), VC2 empty, VC0 non-empty → core_valid_out=0 until VC2's next flit arrives, which is then delivered before any VC0 flit.
- Async reset mid-packet: assert reset between clock edges with all VCs at occupancy 2 and lock=1 → outputs go to their reset values without waiting for a clock edge. After release, the first grant is VC0.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit field positions, port enum and VC index type for the NoC
package noc_pkg;

   // Widest VC index any instance may use; per-instance widths are sliced from this.
   localparam int MAX_VC_W = 4;

   typedef logic [MAX_VC_W-1:0] vc_idx_t;

   typedef enum logic [2:0] {
      NORTH = 3'd0,
      EAST  = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      LOCAL = 3'd4
   } noc_port_e;

   // Head marker is the flit MSB.
   function automatic int head_bit(input int flit_width);
      return flit_width - 1;
   endfunction

   // Tail marker sits just below the head marker.
   function automatic int tail_bit(input int flit_width);
      return flit_width - 2;
   endfunction

   // VC field occupies the MAX_VC_W bits directly below the tail marker.
   function automatic int vc_lsb(input int flit_width);
      return flit_width - 2 - MAX_VC_W;
   endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// rtl/noc_vc_fifo.sv - per-VC flit FIFO with registered ready and fill count
module noc_vc_fifo #(
   parameter int FLIT_WIDTH = 128,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [FLIT_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [FLIT_WIDTH-1:0]         head,
   output logic                          empty,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wptr_q, wptr_d;
   logic [AW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ready_q, ready_d;
   logic                  do_push, do_pop;

   // Pointer/count update; ready looks at the post-edge count so a full FIFO never accepts.
   always_comb begin
      do_push = push && ready_q;
      do_pop  = pop && (count_q != '0);
      wptr_d  = wptr_q + AW'(do_push);
      rptr_d  = rptr_q + AW'(do_pop);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      ready_d = (count_d < CW'(DEPTH));
   end

   // Control state; reset flushes the FIFO and drops ready until the first edge after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ready_q <= ready_d;
      end
   end

   // Flit storage needs no reset: contents are only visible when count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= push_data;
   end

   assign head  = mem_q[rptr_q];
   assign empty = (count_q == '0);
   assign count = count_q;
   assign ready = ready_q;

endmodule

// File: rtl/noc_eject_arbiter.sv
// rtl/noc_eject_arbiter.sv - per-node ejection: per-VC buffering and round-robin serialisation to the core
module noc_eject_arbiter
   import noc_pkg::*;
#(
   parameter int FLIT_WIDTH   = 128,
   parameter int VC_COUNT     = 3,
   parameter int BUFFER_DEPTH = 4,
   parameter int PACKET_LOCK  = 1,
   parameter int TAIL_BIT     = tail_bit(FLIT_WIDTH)
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [VC_COUNT*FLIT_WIDTH-1:0]                 rtr_flit_in,
   input  logic [VC_COUNT-1:0]                            rtr_valid_in,
   output logic [VC_COUNT-1:0]                            rtr_ready_out,
   output logic [FLIT_WIDTH-1:0]                          core_flit_out,
   output logic [((VC_COUNT > 1) ? $clog2(VC_COUNT) : 1)-1:0] core_vc_out,
   output logic                                           core_valid_out,
   input  logic                                           core_ready_in,
   output logic [VC_COUNT*$clog2(BUFFER_DEPTH+1)-1:0]     vc_occupancy
);

   localparam int VCW = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1;
   localparam int CW  = $clog2(BUFFER_DEPTH+1);

   logic [FLIT_WIDTH-1:0] head [VC_COUNT];
   logic [VC_COUNT-1:0]   empty;
   logic [VC_COUNT-1:0]   pop;

   logic [VCW-1:0]        rr_ptr_q, rr_ptr_d;
   logic                  lock_q, lock_d;
   logic [VCW-1:0]        lock_vc_q, lock_vc_d;
   logic                  hold_q, hold_d;
   logic [VCW-1:0]        hold_vc_q, hold_vc_d;
   logic [FLIT_WIDTH-1:0] last_flit_q, last_flit_d;
   logic [VCW-1:0]        last_vc_q, last_vc_d;

   logic [VCW-1:0]        rr_grant, grant;
   logic                  rr_found, fire;

   generate
      for (genvar v = 0; v < VC_COUNT; v++) begin : g_vc
         noc_vc_fifo #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEPTH      (BUFFER_DEPTH)
         ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (rtr_valid_in[v]),
            .push_data (rtr_flit_in[v*FLIT_WIDTH +: FLIT_WIDTH]),
            .pop       (pop[v]),
            .head      (head[v]),
            .empty     (empty[v]),
            .count     (vc_occupancy[v*CW +: CW]),
            .ready     (rtr_ready_out[v])
         );
         assign pop[v] = fire && (grant == VCW'(v));
      end
   endgenerate

   // Round-robin search: first non-empty VC after the last one served.
   always_comb begin
      rr_found = 1'b0;
      rr_grant = rr_ptr_q;
      for (int i = 1; i <= VC_COUNT; i++) begin
         if (!rr_found && !empty[(int'(rr_ptr_q) + i) % VC_COUNT]) begin
            rr_found = 1'b1;
            rr_grant = VCW'((int'(rr_ptr_q) + i) % VC_COUNT);
         end
      end
   end

   // Grant: packet lock first, then a stalled offer is frozen, otherwise round-robin.
   always_comb begin
      if (lock_q) begin
         grant          = lock_vc_q;
         core_valid_out = !empty[lock_vc_q];
      end else if (hold_q) begin
         grant          = hold_vc_q;
         core_valid_out = 1'b1;
      end else begin
         grant          = rr_grant;
         core_valid_out = rr_found;
      end
      core_flit_out = core_valid_out ? head[grant] : last_flit_q;
      core_vc_out   = core_valid_out ? grant : last_vc_q;
      fire          = core_valid_out && core_ready_in;
   end

   // Next state: pointer advances on pop, lock follows the tail marker, stalled offers are held.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      lock_vc_d   = lock_vc_q;
      if (fire) begin
         rr_ptr_d  = grant;
         lock_d    = (PACKET_LOCK != 0) && !core_flit_out[TAIL_BIT];
         lock_vc_d = grant;
      end
      hold_d      = core_valid_out && !core_ready_in;
      hold_vc_d   = grant;
      last_flit_d = core_flit_out;
      last_vc_d   = core_vc_out;
   end

   // Arbiter state; rr_ptr resets to the last VC so VC0 is served first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q    <= VCW'(VC_COUNT-1);
         lock_q      <= 1'b0;
         lock_vc_q   <= '0;
         hold_q      <= 1'b0;
         hold_vc_q   <= '0;
         last_flit_q <= '0;
         last_vc_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         lock_q      <= lock_d;
         lock_vc_q   <= lock_vc_d;
         hold_q      <= hold_d;
         hold_vc_q   <= hold_vc_d;
         last_flit_q <= last_flit_d;
         last_vc_q   <= last_vc_d;
      end
   end

endmodule

// File: tb/tb_noc_eject_arbiter.sv
// tb/tb_noc_eject_arbiter.sv - directed self-checking bench for noc_eject_arbiter
module tb_noc_eject_arbiter;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [383:0] flit_in;
   logic [2:0]   vin;
   logic         cready;

   logic [2:0]   rdy,    rdy_nl;
   logic [127:0] flit_o, flit_o_nl;
   logic [1:0]   vc_o,   vc_o_nl;
   logic         val_o,  val_o_nl;
   logic [8:0]   occ,    occ_nl;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   noc_eject_arbiter #(.FLIT_WIDTH(128), .VC_COUNT(3), .BUFFER_DEPTH(4), .PACKET_LOCK(1)) dut (
      .clk(clk), .reset(reset), .rtr_flit_in(flit_in), .rtr_valid_in(vin), .rtr_ready_out(rdy),
      .core_flit_out(flit_o), .core_vc_out(vc_o), .core_valid_out(val_o),
      .core_ready_in(cready), .vc_occupancy(occ)
   );

   noc_eject_arbiter #(.FLIT_WIDTH(128), .VC_COUNT(3), .BUFFER_DEPTH(4), .PACKET_LOCK(0)) dut_nl (
      .clk(clk), .reset(reset), .rtr_flit_in(flit_in), .rtr_valid_in(vin), .rtr_ready_out(rdy_nl),
      .core_flit_out(flit_o_nl), .core_vc_out(vc_o_nl), .core_valid_out(val_o_nl),
      .core_ready_in(cready), .vc_occupancy(occ_nl)
   );

   typedef struct {
      logic [2:0] vin;
      logic [7:0] id0, id1, id2;
      logic       cready;
      logic       ev;
      logic [1:0] evc;
      logic [7:0] eid;
      logic [2:0] eo0, eo1, eo2;
      logic [2:0] erdy;
   } vec_t;

   vec_t tbl [14];

   function automatic logic [127:0] mk(input logic h, input logic t, input logic [7:0] id);
      logic [127:0] f;
      f = '0;
      f[127] = h;
      f[126] = t;
      f[7:0] = id;
      return f;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [2:0] v, input logic [127:0] f0, input logic [127:0] f1,
                         input logic [127:0] f2);
      vin     = v;
      flit_in = {f2, f1, f0};
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      cready = 1'b0;
      set_in(3'b000, '0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   int           n, n_nl, pushed, npop;
   logic [1:0]   ord [4];
   logic [7:0]   ids [4];
   logic [1:0]   ord_nl [4];
   logic [7:0]   ids_nl [4];
   logic [7:0]   popped [8];
   logic [1:0]   exp_ord [4];
   logic [7:0]   exp_ids [4];
   logic [1:0]   exp_ord_nl [4];
   logic [7:0]   exp_ids_nl [4];

   initial begin
      tbl[0]  = '{3'b100, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b1, 2'd2, 8'hA5, 3'd0, 3'd0, 3'd1, 3'b111};
      tbl[1]  = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2, 8'hA5, 3'd0, 3'd0, 3'd0, 3'b111};
      tbl[2]  = '{3'b111, 8'h10, 8'h20, 8'h30, 1'b0, 1'b1, 2'd0, 8'h10, 3'd1, 3'd1, 3'd1, 3'b111};
      tbl[3]  = '{3'b111, 8'h11, 8'h21, 8'h31, 1'b0, 1'b1, 2'd0, 8'h10, 3'd2, 3'd2, 3'd2, 3'b111};
      tbl[4]  = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd1, 8'h20, 3'd1, 3'd2, 3'd2, 3'b111};
      tbl[5]  = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd2, 8'h30, 3'd1, 3'd1, 3'd2, 3'b111};
      tbl[6]  = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0, 8'h11, 3'd1, 3'd1, 3'd1, 3'b111};
      tbl[7]  = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd1, 8'h21, 3'd0, 3'd1, 3'd1, 3'b111};
      tbl[8]  = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd2, 8'h31, 3'd0, 3'd0, 3'd1, 3'b111};
      tbl[9]  = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2, 8'h31, 3'd0, 3'd0, 3'd0, 3'b111};
      tbl[10] = '{3'b100, 8'h00, 8'h00, 8'h40, 1'b0, 1'b1, 2'd2, 8'h40, 3'd0, 3'd0, 3'd1, 3'b111};
      tbl[11] = '{3'b001, 8'h50, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2, 8'h40, 3'd1, 3'd0, 3'd1, 3'b111};
      tbl[12] = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0, 8'h50, 3'd1, 3'd0, 3'd0, 3'b111};
      tbl[13] = '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 8'h50, 3'd0, 3'd0, 3'd0, 3'b111};

      exp_ord    = '{2'd1, 2'd1, 2'd1, 2'd0};
      exp_ids    = '{8'h61, 8'h62, 8'h63, 8'h70};
      exp_ord_nl = '{2'd1, 2'd0, 2'd1, 2'd1};
      exp_ids_nl = '{8'h61, 8'h70, 8'h62, 8'h63};

      // Reset values while reset is held
      cready = 1'b0;
      set_in(3'b000, '0, '0, '0);
      @(negedge clk);
      chk("rst_ready", 128'(rdy), 128'(3'b000));
      chk("rst_valid", 128'(val_o), 128'(1'b0));
      chk("rst_flit", flit_o, 128'(0));
      chk("rst_vc", 128'(vc_o), 128'(2'd0));
      chk("rst_occ", 128'(occ), 128'(9'd0));
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_release", 128'(rdy), 128'(3'b111));

      // Table: single flit latency, round-robin order, held offer
      for (int r = 0; r < 14; r++) begin
         cready = tbl[r].cready;
         set_in(tbl[r].vin, mk(1'b1, 1'b1, tbl[r].id0), mk(1'b1, 1'b1, tbl[r].id1),
                mk(1'b1, 1'b1, tbl[r].id2));
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", r), 128'(val_o), 128'(tbl[r].ev));
         chk($sformatf("tbl%0d_vc", r), 128'(vc_o), 128'(tbl[r].evc));
         chk($sformatf("tbl%0d_flit", r), flit_o, mk(1'b1, 1'b1, tbl[r].eid));
         chk($sformatf("tbl%0d_occ", r), 128'(occ), 128'({tbl[r].eo2, tbl[r].eo1, tbl[r].eo0}));
         chk($sformatf("tbl%0d_ready", r), 128'(rdy), 128'(tbl[r].erdy));
         chk($sformatf("tbl%0d_nl_valid", r), 128'(val_o_nl), 128'(tbl[r].ev));
         chk($sformatf("tbl%0d_nl_vc", r), 128'(vc_o_nl), 128'(tbl[r].evc));
      end

      // Packet lock vs per-flit round-robin
      do_reset();
      set_in(3'b010, '0, mk(1'b1, 1'b0, 8'h61), '0);
      @(negedge clk);
      set_in(3'b011, mk(1'b1, 1'b1, 8'h70), mk(1'b0, 1'b0, 8'h62), '0);
      @(negedge clk);
      set_in(3'b010, '0, mk(1'b0, 1'b1, 8'h63), '0);
      @(negedge clk);
      set_in(3'b000, '0, '0, '0);
      cready = 1'b1;
      n = 0;
      n_nl = 0;
      for (int c = 0; c < 10; c++) begin
         if (val_o && n < 4) begin
            ord[n] = vc_o;
            ids[n] = flit_o[7:0];
            n++;
         end
         if (val_o_nl && n_nl < 4) begin
            ord_nl[n_nl] = vc_o_nl;
            ids_nl[n_nl] = flit_o_nl[7:0];
            n_nl++;
         end
         @(negedge clk);
      end
      chk("lock_count", 128'(n), 128'(4));
      chk("nolock_count", 128'(n_nl), 128'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < n) begin
            chk($sformatf("lock_vc%0d", i), 128'(ord[i]), 128'(exp_ord[i]));
            chk($sformatf("lock_id%0d", i), 128'(ids[i]), 128'(exp_ids[i]));
         end
         if (i < n_nl) begin
            chk($sformatf("nolock_vc%0d", i), 128'(ord_nl[i]), 128'(exp_ord_nl[i]));
            chk($sformatf("nolock_id%0d", i), 128'(ids_nl[i]), 128'(exp_ids_nl[i]));
         end
      end

      // Backpressure and full FIFO on VC0
      do_reset();
      pushed = 0;
      npop = 0;
      for (int c = 0; c < 14; c++) begin
         if (c == 4 || c == 6) begin
            chk($sformatf("full_ready_c%0d", c), 128'(rdy[0]), 128'(1'b0));
            chk($sformatf("full_occ_c%0d", c), 128'(occ[2:0]), 128'(3'd4));
            chk($sformatf("full_valid_c%0d", c), 128'(val_o), 128'(1'b1));
            chk($sformatf("full_flit_c%0d", c), flit_o, mk(1'b1, 1'b1, 8'h81));
         end
         cready = (c >= 6);
         if (cready && val_o && npop < 8) begin
            popped[npop] = flit_o[7:0];
            npop++;
         end
         if (pushed < 5) set_in(3'b001, mk(1'b1, 1'b1, 8'(8'h81 + pushed)), '0, '0);
         else set_in(3'b000, '0, '0, '0);
         if (pushed < 5 && rdy[0]) pushed++;
         @(negedge clk);
      end
      chk("full_pop_count", 128'(npop), 128'(5));
      for (int i = 0; i < 5; i++) begin
         if (i < npop) chk($sformatf("full_order%0d", i), 128'(popped[i]), 128'(8'(8'h81 + i)));
      end
      chk("full_ready_back", 128'(rdy[0]), 128'(1'b1));
      chk("full_occ_drained", 128'(occ[2:0]), 128'(3'd0));

      // Locked on an empty VC
      do_reset();
      set_in(3'b100, '0, '0, mk(1'b1, 1'b0, 8'h90));
      @(negedge clk);
      chk("lockempty_first_vc", 128'(vc_o), 128'(2'd2));
      set_in(3'b001, mk(1'b1, 1'b1, 8'h91), '0, '0);
      cready = 1'b1;
      @(negedge clk);
      chk("lockempty_valid0", 128'(val_o), 128'(1'b0));
      chk("lockempty_occ", 128'(occ), 128'({3'd0, 3'd0, 3'd1}));
      set_in(3'b000, '0, '0, '0);
      @(negedge clk);
      chk("lockempty_valid1", 128'(val_o), 128'(1'b0));
      set_in(3'b100, '0, '0, mk(1'b0, 1'b1, 8'h92));
      @(negedge clk);
      chk("lockempty_vc2_vc", 128'(vc_o), 128'(2'd2));
      chk("lockempty_vc2_flit", flit_o, mk(1'b0, 1'b1, 8'h92));
      set_in(3'b000, '0, '0, '0);
      @(negedge clk);
      chk("lockempty_vc0_vc", 128'(vc_o), 128'(2'd0));
      chk("lockempty_vc0_flit", flit_o, mk(1'b1, 1'b1, 8'h91));

      // Asynchronous reset mid-packet
      do_reset();
      set_in(3'b111, mk(1'b1, 1'b0, 8'hB0), mk(1'b1, 1'b1, 8'hB1), mk(1'b1, 1'b1, 8'hB2));
      @(negedge clk);
      set_in(3'b111, mk(1'b0, 1'b0, 8'hC0), mk(1'b1, 1'b1, 8'hC1), mk(1'b1, 1'b1, 8'hC2));
      cready = 1'b1;
      @(negedge clk);
      set_in(3'b001, mk(1'b0, 1'b1, 8'hD0), '0, '0);
      cready = 1'b0;
      @(negedge clk);
      chk("arst_pre_occ", 128'(occ), 128'({3'd2, 3'd2, 3'd2}));
      chk("arst_pre_locked_vc", 128'(vc_o), 128'(2'd0));
      chk("arst_pre_flit", flit_o, mk(1'b0, 1'b0, 8'hC0));
      set_in(3'b000, '0, '0, '0);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", 128'(val_o), 128'(1'b0));
      chk("arst_flit", flit_o, 128'(0));
      chk("arst_vc", 128'(vc_o), 128'(2'd0));
      chk("arst_occ", 128'(occ), 128'(9'd0));
      chk("arst_ready", 128'(rdy), 128'(3'b000));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("arst_ready_back", 128'(rdy), 128'(3'b111));
      set_in(3'b111, mk(1'b1, 1'b1, 8'hE0), mk(1'b1, 1'b1, 8'hE1), mk(1'b1, 1'b1, 8'hE2));
      @(negedge clk);
      set_in(3'b000, '0, '0, '0);
      chk("arst_first_grant_vc", 128'(vc_o), 128'(2'd0));
      chk("arst_first_grant_flit", flit_o, mk(1'b1, 1'b1, 8'hE0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
